register_tree_queue: RTL and testbench

Parametrised successor to the fixed-capacity register tree. This block is a register-based binary-heap priority queue with three operations: enqueue, dequeue and replace-top. It has a selectable max/min ordering, occupancy tracking and full/empty flags, plus a ready handshake that covers the level-by-level sift. It sits between schedulers and consumers that need the best-priority item every few cycles at register-file area cost.

---
 rtl/register_tree_pkg.sv | 30 +++
 rtl/register_tree_cmp_swap.sv | 39 +++
 rtl/register_tree_queue.sv | 165 ++++++++++++++++
 tb/tb_register_tree_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/register_tree_pkg.sv
// Shared types and the node ordering rule for the register-tree priority queue.
package register_tree_pkg;

  typedef enum logic [1:0] {
    OpNop  = 2'b00,
    OpEnq  = 2'b01,
    OpDeq  = 2'b10,
    OpRepl = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StSiftDown,
    StSiftUp
  } state_e;

  // Keys are zero-extended to this width before comparing, so any DATA_WIDTH up to it works.
  localparam int unsigned MaxDataWidth = 256;
  typedef logic [MaxDataWidth-1:0] key_t;

  // An invalid node loses to every valid node; two invalid nodes never beat each other.
  function automatic logic better(input logic a_valid, input key_t a_data,
                                  input logic b_valid, input key_t b_data,
                                  input logic min_mode);
    if (!a_valid) return 1'b0;
    if (!b_valid) return 1'b1;
    return min_mode ? (a_data < b_data) : (a_data > b_data);
  endfunction

endpackage

// File: rtl/register_tree_cmp_swap.sv
// One parent plus two children: swaps the parent with its better child when that child is
// strictly better. Nodes are packed as {valid, data}.
module register_tree_cmp_swap
  import register_tree_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MIN_MODE   = 1'b0
) (
  input  logic                en_i,
  input  logic [DATA_WIDTH:0] par_i,
  input  logic [DATA_WIDTH:0] left_i,
  input  logic [DATA_WIDTH:0] right_i,
  output logic [DATA_WIDTH:0] par_o,
  output logic [DATA_WIDTH:0] left_o,
  output logic [DATA_WIDTH:0] right_o
);

  logic                right_wins;
  logic                swap;
  logic [DATA_WIDTH:0] best;

  always_comb begin
    // Left child wins ties.
    right_wins = better(right_i[DATA_WIDTH], key_t'(right_i[DATA_WIDTH-1:0]),
                        left_i[DATA_WIDTH], key_t'(left_i[DATA_WIDTH-1:0]), MIN_MODE);
    best       = right_wins ? right_i : left_i;
    swap       = en_i && better(best[DATA_WIDTH], key_t'(best[DATA_WIDTH-1:0]),
                                par_i[DATA_WIDTH], key_t'(par_i[DATA_WIDTH-1:0]), MIN_MODE);
    par_o   = par_i;
    left_o  = left_i;
    right_o = right_i;
    if (swap) begin
      par_o = best;
      if (right_wins) right_o = par_i;
      else            left_o  = par_i;
    end
  end

endmodule

// File: rtl/register_tree_queue.sv
// Register-based binary-heap priority queue with enqueue, dequeue and replace-top; the heap
// is repaired one tree level per cycle while o_ready is low.
module register_tree_queue
  import register_tree_pkg::*;
#(
  parameter int unsigned QUEUE_SIZE = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MIN_MODE   = 1'b0,
  parameter int unsigned TREE_DEPTH = $clog2(QUEUE_SIZE + 1),
  parameter int unsigned NODES      = 2 ** TREE_DEPTH - 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             i_op_valid,
  input  logic [1:0]                       i_op,
  input  logic [DATA_WIDTH-1:0]            i_data,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic                             o_full,
  output logic                             o_empty,
  output logic                             o_error
);

  localparam int unsigned CntW     = $clog2(QUEUE_SIZE + 1);
  localparam int unsigned IntNodes = (NODES - 1) / 2;
  localparam int unsigned SwN      = (IntNodes > 0) ? IntNodes : 1;
  localparam int unsigned LvlW     = (TREE_DEPTH > 2) ? $clog2(TREE_DEPTH - 1) : 1;
  localparam int unsigned LastLvl  = (TREE_DEPTH > 1) ? TREE_DEPTH - 2 : 0;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } node_t;

  node_t               node_q [NODES];
  node_t               node_d [NODES];
  logic [DATA_WIDTH:0] sw_par [SwN];
  logic [DATA_WIDTH:0] sw_left [SwN];
  logic [DATA_WIDTH:0] sw_right [SwN];
  logic                sw_en [SwN];

  state_e          state_q, state_d;
  logic [LvlW-1:0] lvl_q, lvl_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] last_idx;
  logic            err_q, err_d;

  for (genvar i = 0; i < IntNodes; i++) begin : g_sw
    localparam int unsigned Lvl = $clog2(i + 2) - 1;
    assign sw_en[i] = (state_q != StIdle) && (lvl_q == LvlW'(Lvl));
    register_tree_cmp_swap #(
      .DATA_WIDTH(DATA_WIDTH),
      .MIN_MODE  (MIN_MODE)
    ) u_cmp_swap (
      .en_i   (sw_en[i]),
      .par_i  (node_q[i]),
      .left_i (node_q[2*i+1]),
      .right_i(node_q[2*i+2]),
      .par_o  (sw_par[i]),
      .left_o (sw_left[i]),
      .right_o(sw_right[i])
    );
  end

  always_comb begin
    node_d   = node_q;
    state_d  = state_q;
    lvl_d    = lvl_q;
    count_d  = count_q;
    err_d    = 1'b0;
    last_idx = count_q - CntW'(1);

    // Only one level is enabled at a time, so the enabled cells never share a node.
    for (int i = 0; i < IntNodes; i++) begin
      if (sw_en[i]) begin
        node_d[i]     = sw_par[i];
        node_d[2*i+1] = sw_left[i];
        node_d[2*i+2] = sw_right[i];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_op_valid) begin
          case (op_e'(i_op))
            OpEnq: begin
              if (count_q == CntW'(QUEUE_SIZE)) begin
                err_d = 1'b1;
              end else begin
                node_d[count_q] = '{valid: 1'b1, data: i_data};
                count_d         = count_q + CntW'(1);
                if (TREE_DEPTH > 1) begin
                  state_d = StSiftUp;
                  lvl_d   = LvlW'(LastLvl);
                end
              end
            end
            OpDeq: begin
              if (count_q == '0) begin
                err_d = 1'b1;
              end else begin
                // With one entry last_idx is 0, so the clear below empties the root.
                node_d[0]        = node_q[last_idx];
                node_d[last_idx] = '0;
                count_d          = last_idx;
                if (TREE_DEPTH > 1) begin
                  state_d = StSiftDown;
                  lvl_d   = '0;
                end
              end
            end
            OpRepl: begin
              if (count_q == '0) begin
                err_d = 1'b1;
              end else begin
                node_d[0].data = i_data;
                if (TREE_DEPTH > 1) begin
                  state_d = StSiftDown;
                  lvl_d   = '0;
                end
              end
            end
            default: ;
          endcase
        end
      end
      StSiftDown: begin
        if (lvl_q == LvlW'(LastLvl)) state_d = StIdle;
        else                         lvl_d   = lvl_q + LvlW'(1);
      end
      StSiftUp: begin
        if (lvl_q == '0) state_d = StIdle;
        else             lvl_d   = lvl_q - LvlW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NODES; i++) node_q[i] <= '0;
      state_q <= StIdle;
      lvl_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      node_q  <= node_d;
      state_q <= state_d;
      lvl_q   <= lvl_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = node_q[0].valid;
  assign o_data  = node_q[0].valid ? node_q[0].data : '0;
  assign o_count = count_q;
  assign o_full  = (count_q == CntW'(QUEUE_SIZE));
  assign o_empty = (count_q == '0);
  assign o_error = err_q;

endmodule

// File: tb/tb_register_tree_queue.sv
// Bench for register_tree_queue: a max-heap and a min-heap instance checked every cycle
// against plain-queue models, plus directed literal expectations.
module tb_register_tree_queue;

  localparam int QS = 8;
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        opv  [2];
  logic [1:0]  op   [2];
  logic [31:0] din  [2];
  logic        rdy  [2];
  logic [31:0] dout [2];
  logic        vld  [2];
  logic [3:0]  cnt  [2];
  logic        full [2];
  logic        empty[2];
  logic        err  [2];

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  bit          eerr [2];
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];

  always #5 clk = ~clk;

  register_tree_queue #(.QUEUE_SIZE(QS), .DATA_WIDTH(32), .MIN_MODE(1'b0)) dut_max (
    .CLK(clk), .RST(rst[0]), .i_op_valid(opv[0]), .i_op(op[0]), .i_data(din[0]),
    .o_ready(rdy[0]), .o_data(dout[0]), .o_valid(vld[0]), .o_count(cnt[0]),
    .o_full(full[0]), .o_empty(empty[0]), .o_error(err[0])
  );

  register_tree_queue #(.QUEUE_SIZE(QS), .DATA_WIDTH(32), .MIN_MODE(1'b1)) dut_min (
    .CLK(clk), .RST(rst[1]), .i_op_valid(opv[1]), .i_op(op[1]), .i_data(din[1]),
    .o_ready(rdy[1]), .o_data(dout[1]), .o_valid(vld[1]), .o_count(cnt[1]),
    .o_full(full[1]), .o_empty(empty[1]), .o_error(err[1])
  );

  function automatic int best_idx(input logic [31:0] q[$], input bit mn);
    int b = 0;
    for (int i = 1; i < q.size(); i++)
      if (mn ? (q[i] < q[b]) : (q[i] > q[b])) b = i;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input int w);
    logic [31:0] q[$];
    logic [31:0] best;
    if (w == 0) q = mq0;
    else        q = mq1;
    best = (q.size() == 0) ? 32'd0 : q[best_idx(q, w == 1)];
    chk($sformatf("count%0d", w), 32'(cnt[w]), 32'(q.size()));
    chk($sformatf("full%0d", w), 32'(full[w]), 32'(q.size() == QS));
    chk($sformatf("empty%0d", w), 32'(empty[w]), 32'(q.size() == 0));
    chk($sformatf("error%0d", w), 32'(err[w]), 32'(eerr[w]));
    eerr[w] = 1'b0;
    if (rdy[w]) begin
      chk($sformatf("valid%0d", w), 32'(vld[w]), 32'(q.size() != 0));
      chk($sformatf("data%0d", w), dout[w], best);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp_dut(0);
      cmp_dut(1);
    end
  end

  task automatic model_apply(input int w, input logic [1:0] o, input logic [31:0] d);
    logic [31:0] q[$];
    if (w == 0) q = mq0;
    else        q = mq1;
    if (o == OP_ENQ) begin
      q.push_back(d);
    end else begin
      q.delete(best_idx(q, w == 1));
      if (o == OP_REPL) q.push_back(d);
    end
    if (w == 0) mq0 = q;
    else        mq1 = q;
  endtask

  // Issues one op from a negedge with the DUT ready; returns at the negedge it is ready again.
  task automatic apply(input int w, input logic [1:0] o, input logic [31:0] d, input bit hold);
    bit illegal;
    int n;
    int lows = 0;
    n = (w == 0) ? mq0.size() : mq1.size();
    illegal = (o == OP_ENQ) ? (n == QS) : (n == 0);
    opv[w] = 1'b1;
    op[w]  = o;
    din[w] = d;
    @(posedge clk);
    #1;
    if (illegal) eerr[w] = 1'b1;
    else         model_apply(w, o, d);
    if (hold) begin
      op[w]  = OP_REPL;
      din[w] = 32'd99;
    end else begin
      opv[w] = 1'b0;
    end
    @(negedge clk);
    while (!rdy[w] && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    opv[w] = 1'b0;
    chk($sformatf("busy%0d", w), 32'(lows), illegal ? 32'd0 : 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fill [6];
    logic [31:0] order [8];
    fill  = '{32'd40, 32'd25, 32'd35, 32'd15, 32'd45, 32'd1};
    order = '{32'd45, 32'd40, 32'd35, 32'd25, 32'd15, 32'd10, 32'd5, 32'd1};
    for (int w = 0; w < 2; w++) begin
      rst[w] = 1'b1; opv[w] = 1'b0; op[w] = 2'b00; din[w] = '0; eerr[w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Reset state
    chk("s1 empty", 32'(empty[0]), 32'd1);
    chk("s1 count", 32'(cnt[0]), 32'd0);
    chk("s1 valid", 32'(vld[0]), 32'd0);
    chk("s1 data", dout[0], 32'd0);
    chk("s1 ready", 32'(rdy[0]), 32'd1);
    chk_en = 1'b1;

    apply(0, OP_ENQ, 32'd30, 1'b0);
    apply(0, OP_ENQ, 32'd10, 1'b0);
    apply(0, OP_ENQ, 32'd50, 1'b0);
    apply(0, OP_ENQ, 32'd20, 1'b0);
    chk("s2 data", dout[0], 32'd50);
    chk("s2 count", 32'(cnt[0]), 32'd4);

    apply(0, OP_DEQ, 32'd0, 1'b0);
    chk("s3 data1", dout[0], 32'd30);
    apply(0, OP_DEQ, 32'd0, 1'b0);
    chk("s3 data2", dout[0], 32'd20);
    chk("s3 count", 32'(cnt[0]), 32'd2);

    apply(0, OP_REPL, 32'd5, 1'b1);
    chk("s4 data", dout[0], 32'd10);
    chk("s4 count", 32'(cnt[0]), 32'd2);

    for (int i = 0; i < 6; i++) apply(0, OP_ENQ, fill[i], 1'b0);
    chk("s5 full", 32'(full[0]), 32'd1);
    apply(0, OP_ENQ, 32'd100, 1'b0);
    chk("s5 count full", 32'(cnt[0]), 32'd8);
    chk("s5 top", dout[0], 32'd45);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s5 pop%0d", i), dout[0], order[i]);
      apply(0, OP_DEQ, 32'd0, 1'b0);
    end
    chk("s5 empty", 32'(empty[0]), 32'd1);
    apply(0, OP_DEQ, 32'd0, 1'b0);
    apply(0, OP_REPL, 32'd7, 1'b0);
    chk("s5 empty after", 32'(empty[0]), 32'd1);

    apply(1, OP_ENQ, 32'd7, 1'b0);
    apply(1, OP_ENQ, 32'd3, 1'b0);
    apply(1, OP_ENQ, 32'd9, 1'b0);
    chk("s6 min top", dout[1], 32'd3);

    // Reset pulse while the min heap is mid-sift
    opv[1] = 1'b1; op[1] = OP_ENQ; din[1] = 32'd1;
    @(posedge clk);
    #1;
    mq1.push_back(32'd1);
    opv[1] = 1'b0;
    chk("s6 busy", 32'(rdy[1]), 32'd0);
    #1;
    rst[1] = 1'b1;
    mq1.delete();
    eerr[1] = 1'b0;
    #2;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("s6 empty", 32'(empty[1]), 32'd1);
    chk("s6 ready", 32'(rdy[1]), 32'd1);
    chk("s6 count", 32'(cnt[1]), 32'd0);
    chk("s6 valid", 32'(vld[1]), 32'd0);
    apply(1, OP_ENQ, 32'd4, 1'b0);
    chk("s6 after rst", dout[1], 32'd4);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
